kfps2kb_event_queue: RTL
========================

Name: kfps2kb_event_queue

Overview:
- Sequencer and buffer for the PS/2 keyboard receive core.
- Services the core's level `irq`/`keycode` interface and pulses `clear_keycode` to release it.
- Folds PS/2 set-2 prefix bytes (E0 extended, F0 break) into one event per key, and queues events in a FIFO that the host drains through a valid/ready port.
- Decouples slow host software from the single-entry core, so back-to-back scan codes are not lost or turned into FF errors.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  1 = service core; 0 = leave `kb_irq` pending, no capture.
- kb_irq  in  1  core interrupt, level, held until cleared.
- kb_keycode  in  8  core keycode; FF = core error.
- kb_clear_keycode  out  1  one-cycle clear pulse to core (core samples on falling edge).
- ev_valid  out  1  FIFO head valid.
- ev_data  out  11  head event: [10] err, [9] brk, [8] ext, [7:0] code.
- ev_ready  in  1  host accepts head when `ev_valid` is 1.
- ev_count  out  AW+1  entries currently held (0..DEPTH).
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clear_overflow  in  1  clears `overflow`.

Behaviour:
- **Reset values:** `kb_clear_keycode`=0, `ev_valid`=0, `ev_data`=0, `ev_count`=0, `overflow`=0. State = IDLE; ext/brk prefix flags = 0; FIFO pointers = 0.
- **Reset mid-operation:** everything above is cleared, including any half-built prefix sequence. A core `irq` still high after reset is serviced normally.
- **State machine (IDLE, CLEAR, WAIT):**
  - IDLE: when `enable`=1 and `kb_irq`=1, latch `kb_keycode`, drive `kb_clear_keycode`=1 (registered), go to CLEAR.
  - CLEAR: `kb_clear_keycode` returns to 0; decode the latched byte (below); go to WAIT.
  - WAIT: stay until `kb_irq`=0, then go to IDLE. A new `irq` is not serviced before returning to IDLE.
  - Minimum service period is 3 cycles per byte.
- `enable` is sampled only in IDLE. Dropping it in CLEAR or WAIT does not abort the sequence.
- **Decode, in the CLEAR cycle:**
  - E0: set ext flag; no push.
  - F0: set brk flag; no push.
  - FF or 00: push {err=1, brk=0, ext=0, code=byte}; clear both flags.
  - Any other byte: push {err=0, brk, ext, code=byte}; clear both flags.
  - Repeated E0/F0 bytes only set their flag (idempotent).
- **Push/pop timing:**
  - A pushed event is visible on `ev_valid`/`ev_data` the cycle after the CLEAR edge, when the FIFO was empty.
  - The head is combinational from FIFO storage (first-word fall-through).
  - Pop occurs on a rising edge with `ev_valid`=1 and `ev_ready`=1.
  - `ev_ready` while empty has no effect.
- **Full:**
  - Push with `ev_count`=DEPTH and no pop in the same cycle: event dropped, `overflow` set to 1, contents unchanged. Prefix flags are still cleared.
  - Push and pop in the same cycle when full: both take effect; count stays DEPTH; no overflow.
- **Empty:** push and `ev_ready` in the same cycle → push accepted; nothing popped; count becomes 1.
- **Pointers:** wrap modulo DEPTH. `ev_count` = pushes − pops, never exceeding DEPTH and never going below 0.
- **Overflow flag:** `clear_overflow` clears it on the next edge. If a drop occurs in the same cycle as `clear_overflow`, set wins and `overflow` remains 1.

Test Plan:
- **Single make:** reset; core byte 1C with `irq`; enable=1.
  - `kb_clear_keycode` is high for exactly 1 cycle.
  - `ev_valid`=1 with `ev_data`=0x01C, `ev_count`=1.
  - Pop with `ev_ready` → `ev_count`=0.
- **Extended break:** bytes E0, F0, 75 delivered sequentially.
  - Exactly one event, `ev_data`=0x375.
  - Follow-up byte 75 → event 0x075 (flags cleared).
- **Error codes:** bytes FF, then 00.
  - Events 0x4FF and 0x400.
  - A pending F0 before FF is discarded: F0, FF, 1C gives 0x4FF then 0x01C.
- **Overflow:** DEPTH=8, `ev_ready`=0, push 9 make codes 01..09.
  - `ev_count`=8, `overflow`=1; 09 is lost.
  - Drain returns 01..08 in order.
  - `clear_overflow` → `overflow`=0.
- **Full with simultaneous pop:** FIFO full, byte 2A pushed while `ev_ready`=1.
  - `ev_count` stays 8, `overflow` stays 0.
  - 2A is the last entry drained.
- **Enable and reset:** `enable`=0 with `irq` high for 20 cycles → no `kb_clear_keycode`, `ev_count`=0; `enable`=1 → serviced within 1 cycle. Separately:
  - Assert `reset` in WAIT after an E0 → all outputs at reset values.
  - Next byte 74 yields 0x074 (ext lost).

Source files
------------

// File: rtl/kfps2kb_event_queue.sv
// PS/2 set-2 event sequencer: folds E0/F0 prefixes into one event per key and queues it in a FWFT FIFO.
// Latency: event visible 2 edges after irq is seen; backpressure: ev_ready holds events, full FIFO drops and sets overflow.

module kfps2kb_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic          head_vld,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   count,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign head_vld = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_ok    = pop && head_vld;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_ok    = push && (!full || rd_ok);
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module kfps2kb_event_queue #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          kb_irq,
  input  logic [7:0]    kb_keycode,
  output logic          kb_clear_keycode,
  output logic          ev_valid,
  output logic [10:0]   ev_data,
  input  logic          ev_ready,
  output logic [AW:0]   ev_count,
  output logic          overflow,
  input  logic          clear_overflow
);

  typedef struct packed {
    logic       err;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ev_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       clr_q, clr_d;
  logic [7:0] byte_q;
  logic       capture;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       push;
  ev_t        push_ev;
  logic       pop;
  logic       full;
  logic       drop;
  logic       overflow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_q      <= 1'b0;
      byte_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      if (capture) begin
        byte_q <= kb_keycode;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clear_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    capture = 1'b0;
    ext_d   = ext_q;
    brk_d   = brk_q;
    push    = 1'b0;
    push_ev = '0;
    case (state_q)
      IDLE: begin
        if (enable && kb_irq) begin
          state_d = CLEAR;
          clr_d   = 1'b1;
          capture = 1'b1;
        end
      end
      CLEAR: begin
        state_d = WAIT;
        if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          // Error bytes discard any pending prefix rather than carrying it.
          push         = 1'b1;
          push_ev.code = byte_q;
          if (byte_q == 8'hFF || byte_q == 8'h00) begin
            push_ev.err = 1'b1;
          end else begin
            push_ev.brk = brk_q;
            push_ev.ext = ext_q;
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      WAIT: begin
        if (!kb_irq) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop  = ev_valid && ev_ready;
  assign drop = push && full && !pop;

  kfps2kb_fifo #(
    .W     (11),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_ev),
    .pop      (pop),
    .head_vld (ev_valid),
    .head_dat (ev_data),
    .count    (ev_count),
    .full     (full)
  );

  assign kb_clear_keycode = clr_q;
  assign overflow         = overflow_q;

endmodule
